// File: rtl/riscv_pkg.sv
// Shared constants and types for the fetch front end and later pipeline stages.
package riscv_pkg;

  localparam int DEFAULT_WORDSIZE         = 64;
  localparam int DEFAULT_INSTRUCTION_SIZE = 32;
  localparam int INSTRUCTION_BYTES        = 4;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic {
    RUN,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// Single valid/ready pipeline slot with flush; flush beats load, load beats drain.
module if_id_register
  import riscv_pkg::*;
#(
  parameter int PC_W  = DEFAULT_WORDSIZE,
  parameter int INS_W = DEFAULT_INSTRUCTION_SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [INS_W-1:0] in_instruction,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_instruction
);

  logic             valid_q, valid_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] ins_q, ins_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      ins_d   = in_instruction;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      ins_q   <= INS_W'(NOP_INSTRUCTION);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_instruction = ins_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// fills the IF/ID slot; halts in FAULT on a misaligned or out-of-range PC.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int                          WORDSIZE         = DEFAULT_WORDSIZE,
  parameter int                          INSTRUCTION_SIZE = DEFAULT_INSTRUCTION_SIZE,
  parameter int                          MEMORY_SIZE      = 1024,
  parameter logic [WORDSIZE-1:0]         RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORDSIZE-1:0]         out_pc,
  output logic [INSTRUCTION_SIZE-1:0] out_instruction,
  output logic                        fault
);

  localparam int IDX_W = WORDSIZE - 2;
  localparam logic [IDX_W-1:0] MEM_WORDS = IDX_W'(MEMORY_SIZE);

  logic [WORDSIZE-1:0] pc_q, pc_d;
  fetch_state_t        state_q, state_d;

  logic [IDX_W-1:0] pc_idx, redir_idx;
  logic             pc_ok, redir_ok, slot_free, fire;

  assign pc_idx    = pc_q[WORDSIZE-1:2];
  assign redir_idx = redirect_pc[WORDSIZE-1:2];
  assign pc_ok     = (pc_q[1:0] == 2'b00) && (pc_idx < MEM_WORDS);
  assign redir_ok  = (redirect_pc[1:0] == 2'b00) && (redir_idx < MEM_WORDS);
  assign slot_free = !out_valid || out_ready;
  assign imem_addr = {2'b00, pc_idx};

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    fire    = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = redir_ok ? RUN : FAULT;
    end else if (state_q == RUN) begin
      if (!pc_ok) begin
        state_d = FAULT;
      end else if (!stall && slot_free) begin
        fire = 1'b1;
        pc_d = pc_q + WORDSIZE'(INSTRUCTION_BYTES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign fault = (state_q == FAULT);

  if_id_register #(
    .PC_W  (WORDSIZE),
    .INS_W (INSTRUCTION_SIZE)
  ) u_if_id (
    .clk             (clk),
    .reset           (reset),
    .flush           (redirect_valid),
    .load            (fire),
    .in_pc           (pc_q),
    .in_instruction  (imem_instruction),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch against a behavioural instruction memory.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, out_ready;
  logic [63:0] redirect_pc, imem_addr, out_pc;
  logic [31:0] imem_instruction, out_instruction;
  logic        out_valid, fault;

  logic [31:0] mem [0:1023];

  typedef struct packed {
    logic        vld;
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign imem_instruction = (imem_addr < 64'd1024) ? mem[imem_addr[9:0]] : 32'hDEAD_BEEF;

  instruction_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_instruction  (out_instruction),
    .fault            (fault)
  );

  function automatic exp_t slot(input logic v, input logic [63:0] pc, input logic [31:0] ins);
    slot.vld = v;
    slot.pc  = pc;
    slot.ins = ins;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    sb.push_back(slot(1'b0, 64'h0, NOP));
    step();
    e = sb.pop_front(); checks++;
    if ({out_valid, out_pc, out_instruction} !== e) begin
      errors++; $display("FAIL reset_slot got %h want %h", {out_valid, out_pc, out_instruction}, e);
    end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    checks++;
    if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    reset = 1'b0; redirect_valid = 1'b0;
    sb.push_back(slot(1'b1, 64'h0, mem[0]));
    step();
    e = sb.pop_front(); checks++;
    if ({out_valid, out_pc, out_instruction} !== e) begin
      errors++; $display("FAIL reset_first got %h want %h", {out_valid, out_pc, out_instruction}, e);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      sb.push_back(slot(1'b1, 64'(4 * k), mem[k]));
      step();
      e = sb.pop_front(); checks++;
      if ({out_valid, out_pc, out_instruction} !== e) begin
        errors++; $display("FAIL seq[%0d] got %h want %h", k, {out_valid, out_pc, out_instruction}, e);
      end
    end
    checks++;
    if (imem_addr !== 64'd4) begin errors++; $display("FAIL seq_addr got %h want 4", imem_addr); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(slot(1'b1, 64'h0, mem[0]));
      step();
      e = sb.pop_front(); checks++;
      if ({out_valid, out_pc, out_instruction} !== e) begin
        errors++; $display("FAIL bp_hold[%0d] got %h want %h", k, {out_valid, out_pc, out_instruction}, e);
      end
      checks++;
      if (imem_addr !== 64'd1) begin errors++; $display("FAIL bp_pc[%0d] got %h want 1", k, imem_addr); end
    end
    out_ready = 1'b1;
    sb.push_back(slot(1'b1, 64'h4, mem[1]));
    step();
    e = sb.pop_front(); checks++;
    if ({out_valid, out_pc, out_instruction} !== e) begin
      errors++; $display("FAIL bp_release got %h want %h", {out_valid, out_pc, out_instruction}, e);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    sb.push_back(slot(1'b1, 64'h0, mem[0]));
    sb.push_back(slot(1'b1, 64'h4, mem[1]));
    sb.push_back(slot(1'b0, 64'h4, mem[1]));
    sb.push_back(slot(1'b0, 64'h4, mem[1]));
    sb.push_back(slot(1'b1, 64'h8, mem[2]));
    for (int k = 0; k < 5; k++) begin
      stall = (k == 2 || k == 3);
      step();
      e = sb.pop_front(); checks++;
      if ({out_valid, out_pc, out_instruction} !== e) begin
        errors++; $display("FAIL stall[%0d] got %h want %h", k, {out_valid, out_pc, out_instruction}, e);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect();
    apply_reset();
    sb.push_back(slot(1'b1, 64'h0, mem[0]));
    step();
    e = sb.pop_front(); checks++;
    if ({out_valid, out_pc, out_instruction} !== e) begin
      errors++; $display("FAIL redir_pre got %h want %h", {out_valid, out_pc, out_instruction}, e);
    end
    redirect_valid = 1'b1; redirect_pc = 64'h40; stall = 1'b1; out_ready = 1'b0;
    sb.push_back(slot(1'b0, 64'h0, mem[0]));
    step();
    e = sb.pop_front(); checks++;
    if ({out_valid, out_pc, out_instruction} !== e) begin
      errors++; $display("FAIL redir_flush got %h want %h", {out_valid, out_pc, out_instruction}, e);
    end
    checks++;
    if (imem_addr !== 64'h10) begin errors++; $display("FAIL redir_addr got %h want 10", imem_addr); end
    redirect_valid = 1'b0; stall = 1'b0; out_ready = 1'b1;
    sb.push_back(slot(1'b1, 64'h40, mem[16]));
    step();
    e = sb.pop_front(); checks++;
    if ({out_valid, out_pc, out_instruction} !== e) begin
      errors++; $display("FAIL redir_target got %h want %h", {out_valid, out_pc, out_instruction}, e);
    end
  endtask

  task automatic test_fault();
    apply_reset();
    redirect_valid = 1'b1; redirect_pc = 64'h42;
    for (int k = 0; k < 5; k++) begin
      logic want_fault;
      if (k == 1) redirect_valid = 1'b0;
      if (k == 3) begin redirect_valid = 1'b1; redirect_pc = 64'h8; end
      if (k == 4) redirect_valid = 1'b0;
      want_fault = (k < 3);
      sb.push_back(k == 4 ? slot(1'b1, 64'h8, mem[2]) : slot(1'b0, 64'h0, NOP));
      step();
      e = sb.pop_front(); checks++;
      if ({out_valid, out_pc, out_instruction} !== e) begin
        errors++; $display("FAIL fault_slot[%0d] got %h want %h", k, {out_valid, out_pc, out_instruction}, e);
      end
      checks++;
      if (fault !== want_fault) begin
        errors++; $display("FAIL fault_flag[%0d] got %b want %b", k, fault, want_fault);
      end
    end
  endtask

  task automatic test_range_end();
    logic want_fault;
    apply_reset();
    redirect_valid = 1'b1; redirect_pc = 64'hFF8;
    step();
    redirect_valid = 1'b0;
    // k=2: slot held under backpressure as FAULT is entered; k=3: drained while faulted
    for (int k = 0; k < 4; k++) begin
      out_ready = (k != 2);
      case (k)
        0:       sb.push_back(slot(1'b1, 64'hFF8, mem[1022]));
        1, 2:    sb.push_back(slot(1'b1, 64'hFFC, mem[1023]));
        default: sb.push_back(slot(1'b0, 64'hFFC, mem[1023]));
      endcase
      want_fault = (k >= 2);
      step();
      e = sb.pop_front(); checks++;
      if ({out_valid, out_pc, out_instruction} !== e) begin
        errors++; $display("FAIL end_slot[%0d] got %h want %h", k, {out_valid, out_pc, out_instruction}, e);
      end
      checks++;
      if (fault !== want_fault) begin
        errors++; $display("FAIL end_fault[%0d] got %b want %b", k, fault, want_fault);
      end
    end
    reset = 1'b1;
    sb.push_back(slot(1'b0, 64'h0, NOP));
    step();
    e = sb.pop_front(); checks++;
    if ({out_valid, out_pc, out_instruction, fault, imem_addr} !== {e, 1'b0, 64'h0}) begin
      errors++; $display("FAIL end_reset got %h f=%b a=%h want %h f=0 a=0",
                         {out_valid, out_pc, out_instruction}, fault, imem_addr, e);
    end
    reset = 1'b0;
    sb.push_back(slot(1'b1, 64'h0, mem[0]));
    step();
    e = sb.pop_front(); checks++;
    if ({out_valid, out_pc, out_instruction} !== e) begin
      errors++; $display("FAIL end_restart got %h want %h", {out_valid, out_pc, out_instruction}, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h9E37_79B1 * 32'(i) + 32'h0000_0013;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_stall();
    test_redirect();
    test_fault();
    test_range_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
